// File: rtl/riscv_cpu.sv
// ============================================================================
// Module      : riscv_cpu
// Description : Five-stage in-order RV32I-subset core with on-chip instruction
//               and data memories. Define FORWARDING_EN to build the EX bypass
//               network; without it, RAW hazards stall in ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_cpu (
    input  logic clock,
    input  logic reset
);
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    bne;
        logic    jal;
        logic    use_imm;
        alu_op_e alu_op;
    } ctrl_t;

    logic [31:0] pc_q, pc_d, pc_if, instruction_if;
    logic [31:0] ifid_pc_q, ifid_instr_q;
    ctrl_t       idex_ctrl_q;
    logic [31:0] idex_pc_q, idex_rs1_val_q, idex_rs2_val_q, idex_imm_q;
    logic [4:0]  idex_rd_q;
    logic        exmem_reg_write_q, exmem_mem_read_q, exmem_mem_write_q;
    logic [4:0]  exmem_rd_q;
    logic [31:0] exmem_result_q, exmem_store_q;
    logic        memwb_reg_write_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_data_q;
`ifdef FORWARDING_EN
    logic [4:0]  idex_rs1_q, idex_rs2_q;
`endif

    assign pc_if = pc_q;

    riscv_imem imem (
        .clock   (clock),
        .we_i    (1'b0),
        .waddr_i (10'd0),
        .wdata_i (8'd0),
        .addr_i  (pc_q[9:0]),
        .rdata_o (instruction_if)
    );

    // ---------------- ID: decode ----------------
    logic [6:0]  id_opcode;
    logic [2:0]  id_f3;
    logic [6:0]  id_f7;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [31:0] id_imm, id_rs1_val, id_rs2_val;
    logic        id_use1, id_use2;
    ctrl_t       id_ctrl;

    assign id_opcode = ifid_instr_q[6:0];
    assign id_rd     = ifid_instr_q[11:7];
    assign id_f3     = ifid_instr_q[14:12];
    assign id_rs1    = ifid_instr_q[19:15];
    assign id_rs2    = ifid_instr_q[24:20];
    assign id_f7     = ifid_instr_q[31:25];

    always_comb begin
        id_ctrl = '0;
        id_use1 = 1'b0;
        id_use2 = 1'b0;
        id_imm  = {{21{ifid_instr_q[31]}}, ifid_instr_q[30:20]};
        case (id_opcode)
            7'b0010011: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                id_use1           = 1'b1;
                case (id_f3)
                    3'b000:  id_ctrl.alu_op = ALU_ADD;
                    3'b111:  id_ctrl.alu_op = ALU_AND;
                    3'b110:  id_ctrl.alu_op = ALU_OR;
                    3'b100:  id_ctrl.alu_op = ALU_XOR;
                    3'b010:  id_ctrl.alu_op = ALU_SLT;
                    default: begin
                        id_ctrl.reg_write = 1'b0;
                        id_use1           = 1'b0;
                    end
                endcase
            end
            7'b0110011: begin
                id_ctrl.reg_write = 1'b1;
                id_use1           = 1'b1;
                id_use2           = 1'b1;
                case ({id_f7, id_f3})
                    10'b0000000_000: id_ctrl.alu_op = ALU_ADD;
                    10'b0100000_000: id_ctrl.alu_op = ALU_SUB;
                    10'b0000000_111: id_ctrl.alu_op = ALU_AND;
                    10'b0000000_110: id_ctrl.alu_op = ALU_OR;
                    10'b0000000_100: id_ctrl.alu_op = ALU_XOR;
                    10'b0000000_010: id_ctrl.alu_op = ALU_SLT;
                    default: begin
                        id_ctrl.reg_write = 1'b0;
                        id_use1           = 1'b0;
                        id_use2           = 1'b0;
                    end
                endcase
            end
            7'b0110111: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                id_ctrl.alu_op    = ALU_PASSB;
                id_imm            = {ifid_instr_q[31:12], 12'd0};
            end
            7'b0000011: begin
                if (id_f3 == 3'b010) begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.mem_read  = 1'b1;
                    id_ctrl.use_imm   = 1'b1;
                    id_use1           = 1'b1;
                end
            end
            7'b0100011: begin
                id_imm = {{21{ifid_instr_q[31]}}, ifid_instr_q[30:25], ifid_instr_q[11:7]};
                if (id_f3 == 3'b010) begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.use_imm   = 1'b1;
                    id_use1           = 1'b1;
                    id_use2           = 1'b1;
                end
            end
            7'b1100011: begin
                id_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[7], ifid_instr_q[30:25],
                          ifid_instr_q[11:8], 1'b0};
                if (id_f3[2:1] == 2'b00) begin
                    id_ctrl.branch = 1'b1;
                    id_ctrl.bne    = id_f3[0];
                    id_use1        = 1'b1;
                    id_use2        = 1'b1;
                end
            end
            7'b1101111: begin
                id_imm = {{12{ifid_instr_q[31]}}, ifid_instr_q[19:12], ifid_instr_q[20],
                          ifid_instr_q[30:21], 1'b0};
                id_ctrl.reg_write = 1'b1;
                id_ctrl.jal       = 1'b1;
            end
            default: ;
        endcase
        // x0 destinations never write, which also keeps them out of hazard matching
        if (id_rd == 5'd0) id_ctrl.reg_write = 1'b0;
    end

    riscv_regfile regfile (
        .clock    (clock),
        .reset    (reset),
        .raddr1_i (id_rs1),
        .raddr2_i (id_rs2),
        .rdata1_o (id_rs1_val),
        .rdata2_o (id_rs2_val),
        .we_i     (memwb_reg_write_q),
        .waddr_i  (memwb_rd_q),
        .wdata_i  (memwb_data_q)
    );

    // ---------------- Hazard unit ----------------
    logic id_hit_ex, stall;
    assign id_hit_ex = idex_ctrl_q.reg_write &&
                       ((id_use1 && id_rs1 == idex_rd_q) || (id_use2 && id_rs2 == idex_rd_q));
`ifdef FORWARDING_EN
    assign stall = id_hit_ex && idex_ctrl_q.mem_read;
`else
    logic id_hit_mem;
    assign id_hit_mem = exmem_reg_write_q &&
                        ((id_use1 && id_rs1 == exmem_rd_q) || (id_use2 && id_rs2 == exmem_rd_q));
    assign stall = id_hit_ex || id_hit_mem;
`endif

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y, ex_result, ex_target;
    logic        ex_take;

`ifdef FORWARDING_EN
    always_comb begin
        fwd_a = idex_rs1_val_q;
        fwd_b = idex_rs2_val_q;
        if (exmem_reg_write_q && exmem_rd_q == idex_rs1_q)      fwd_a = exmem_result_q;
        else if (memwb_reg_write_q && memwb_rd_q == idex_rs1_q) fwd_a = memwb_data_q;
        if (exmem_reg_write_q && exmem_rd_q == idex_rs2_q)      fwd_b = exmem_result_q;
        else if (memwb_reg_write_q && memwb_rd_q == idex_rs2_q) fwd_b = memwb_data_q;
    end
`else
    assign fwd_a = idex_rs1_val_q;
    assign fwd_b = idex_rs2_val_q;
`endif

    assign alu_b = idex_ctrl_q.use_imm ? idex_imm_q : fwd_b;

    always_comb begin
        case (idex_ctrl_q.alu_op)
            ALU_ADD:   alu_y = fwd_a + alu_b;
            ALU_SUB:   alu_y = fwd_a - alu_b;
            ALU_AND:   alu_y = fwd_a & alu_b;
            ALU_OR:    alu_y = fwd_a | alu_b;
            ALU_XOR:   alu_y = fwd_a ^ alu_b;
            ALU_SLT:   alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = 32'd0;
        endcase
    end

    assign ex_result = idex_ctrl_q.jal ? idex_pc_q + 32'd4 : alu_y;
    assign ex_target = idex_pc_q + idex_imm_q;
    assign ex_take   = idex_ctrl_q.jal ||
                       (idex_ctrl_q.branch && ((fwd_a == fwd_b) ^ idex_ctrl_q.bne));

    assign pc_d = ex_take ? ex_target : (stall ? pc_q : pc_q + 32'd4);

    // ---------------- MEM ----------------
    logic [31:0] mem_rdata;
    riscv_dmem dmem (
        .clock   (clock),
        .we_i    (exmem_mem_write_q),
        .word_i  (exmem_result_q[9:2]),
        .wdata_i (exmem_store_q),
        .rdata_o (mem_rdata)
    );

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q              <= '0;
            ifid_pc_q         <= '0;
            ifid_instr_q      <= '0;
            idex_ctrl_q       <= '0;
            idex_pc_q         <= '0;
            idex_rs1_val_q    <= '0;
            idex_rs2_val_q    <= '0;
            idex_imm_q        <= '0;
            idex_rd_q         <= '0;
`ifdef FORWARDING_EN
            idex_rs1_q        <= '0;
            idex_rs2_q        <= '0;
`endif
            exmem_reg_write_q <= 1'b0;
            exmem_mem_read_q  <= 1'b0;
            exmem_mem_write_q <= 1'b0;
            exmem_rd_q        <= '0;
            exmem_result_q    <= '0;
            exmem_store_q     <= '0;
            memwb_reg_write_q <= 1'b0;
            memwb_rd_q        <= '0;
            memwb_data_q      <= '0;
        end else begin
            pc_q <= pc_d;
            // An all-zero word decodes as a NOP, so it doubles as the IF/ID bubble
            if (ex_take) begin
                ifid_pc_q    <= '0;
                ifid_instr_q <= '0;
            end else if (!stall) begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= instruction_if;
            end
            idex_ctrl_q       <= (ex_take || stall) ? '0 : id_ctrl;
            idex_pc_q         <= ifid_pc_q;
            idex_rs1_val_q    <= id_rs1_val;
            idex_rs2_val_q    <= id_rs2_val;
            idex_imm_q        <= id_imm;
            idex_rd_q         <= id_rd;
`ifdef FORWARDING_EN
            idex_rs1_q        <= id_rs1;
            idex_rs2_q        <= id_rs2;
`endif
            exmem_reg_write_q <= idex_ctrl_q.reg_write;
            exmem_mem_read_q  <= idex_ctrl_q.mem_read;
            exmem_mem_write_q <= idex_ctrl_q.mem_write;
            exmem_rd_q        <= idex_rd_q;
            exmem_result_q    <= ex_result;
            exmem_store_q     <= fwd_b;
            memwb_reg_write_q <= exmem_reg_write_q;
            memwb_rd_q        <= exmem_rd_q;
            memwb_data_q      <= exmem_mem_read_q ? mem_rdata : exmem_result_q;
        end
    end
endmodule

// Byte-wide instruction store; contents are preloaded from outside and never reset.
module riscv_imem (
    input  logic        clock,
    input  logic        we_i,
    input  logic [9:0]  waddr_i,
    input  logic [7:0]  wdata_i,
    input  logic [9:0]  addr_i,
    output logic [31:0] rdata_o
);
    logic [7:0] memory [0:1023];

    always_ff @(posedge clock) begin
        if (we_i) memory[waddr_i] <= wdata_i;
    end

    assign rdata_o = {memory[addr_i + 10'd3], memory[addr_i + 10'd2],
                      memory[addr_i + 10'd1], memory[addr_i]};
endmodule

// Word-addressed little-endian data store: synchronous write, combinational read.
module riscv_dmem (
    input  logic        clock,
    input  logic        we_i,
    input  logic [7:0]  word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [7:0] memory [0:1023];

    always_ff @(posedge clock) begin
        if (we_i) begin
            memory[{word_i, 2'd0}] <= wdata_i[7:0];
            memory[{word_i, 2'd1}] <= wdata_i[15:8];
            memory[{word_i, 2'd2}] <= wdata_i[23:16];
            memory[{word_i, 2'd3}] <= wdata_i[31:24];
        end
    end

    assign rdata_o = {memory[{word_i, 2'd3}], memory[{word_i, 2'd2}],
                      memory[{word_i, 2'd1}], memory[{word_i, 2'd0}]};
endmodule

// 32x32 register file; WB data bypasses to same-cycle reads so ID never sees stale values.
module riscv_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 :
                      (we_i && waddr_i == raddr1_i) ? wdata_i : registers[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 :
                      (we_i && waddr_i == raddr2_i) ? wdata_i : registers[raddr2_i];
endmodule

`default_nettype wire

// File: tb/tb_riscv_cpu.sv
// ============================================================================
// Module      : tb_riscv_cpu
// Description : Directed programs for riscv_cpu with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_cpu;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef FORWARDING_EN
    localparam int BB_X3_EDGE = 7;
    localparam int LU_X3_EDGE = 9;
`else
    localparam int BB_X3_EDGE = 11;
    localparam int LU_X3_EDGE = 12;
`endif

    riscv_cpu dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.imem.memory[addr]     = w[7:0];
        dut.imem.memory[addr + 1] = w[15:8];
        dut.imem.memory[addr + 2] = w[23:16];
        dut.imem.memory[addr + 3] = w[31:24];
    endtask

    task automatic hold_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) dut.imem.memory[i] = 8'h00;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] xr(input int i);
        return dut.regfile.registers[i];
    endfunction

    logic [31:0] alu_exp [7:22];

    initial begin
        // Single instruction: latency and PC sequence
        hold_reset();
        put(0, 32'h00A00513);
        release_reset();
        check("pc_release", dut.pc_if, 32'd0);
        check("instr_fetch0", dut.instruction_if, 32'h00A00513);
        tick(1);
        check("pc_edge1", dut.pc_if, 32'd4);
        tick(1);
        check("pc_edge2", dut.pc_if, 32'd8);
        tick(2);
        check("x10_edge4", xr(10), 32'd0);
        tick(1);
        check("x10_edge5", xr(10), 32'h0000000A);

        // Back-to-back dependence
        hold_reset();
        put(0, 32'h00500093);
        put(4, 32'h00108133);
        put(8, 32'h401101B3);
        release_reset();
        tick(BB_X3_EDGE - 1);
        check("bb_x3_early", xr(3), 32'd0);
        tick(1);
        check("bb_x3", xr(3), 32'd5);
        check("bb_x2", xr(2), 32'd10);
        check("bb_x1", xr(1), 32'd5);

        // Load-use through data memory
        hold_reset();
        put(0,  32'h05500093);
        put(4,  32'h00102423);
        put(8,  32'h00802103);
        put(12, 32'h00110193);
        release_reset();
        tick(LU_X3_EDGE - 1);
        check("lu_x3_early", xr(3), 32'd0);
        tick(1);
        check("lu_x3", xr(3), 32'h00000056);
        check("lu_x2", xr(2), 32'h00000055);

        // Taken BEQ flushes the shadow instruction
        hold_reset();
        put(0,  32'h00100093);
        put(4,  32'h00108463);
        put(8,  32'h00700213);
        put(12, 32'h00900293);
        release_reset();
        tick(20);
        check("br_x1", xr(1), 32'd1);
        check("br_x4", xr(4), 32'd0);
        check("br_x5", xr(5), 32'd9);

        // JAL link, redirect timing and x0 immutability
        hold_reset();
        put(0, 32'h008000EF);
        put(4, 32'h00100313);
        put(8, 32'h00300013);
        release_reset();
        tick(3);
        check("jal_pc_edge3", dut.pc_if, 32'd8);
        tick(12);
        check("jal_x1", xr(1), 32'd4);
        check("jal_x0", xr(0), 32'd0);
        check("jal_x6", xr(6), 32'd0);

        // ALU mix, BNE both ways, unsupported encoding, forwarding priority
        hold_reset();
        put(0,  32'h123453B7);
        put(4,  32'hFFD00413);
        put(8,  32'h00142493);
        put(12, 32'h0F047513);
        put(16, 32'h12306593);
        put(20, 32'hFFF44613);
        put(24, 32'h000426B3);
        put(28, 32'h0083F733);
        put(32, 32'h00C567B3);
        put(36, 32'h00B3C833);
        put(40, 32'h00001463);
        put(44, 32'h00100893);
        put(48, 32'h00041463);
        put(52, 32'h00100913);
        put(56, 32'h00100993);
        put(60, 32'h00141A13);
        put(64, 32'h00100A93);
        put(68, 32'h00200A93);
        put(72, 32'h000A8B33);
        release_reset();
        alu_exp[7]  = 32'h12345000;
        alu_exp[8]  = 32'hFFFFFFFD;
        alu_exp[9]  = 32'h00000001;
        alu_exp[10] = 32'h000000F0;
        alu_exp[11] = 32'h00000123;
        alu_exp[12] = 32'h00000002;
        alu_exp[13] = 32'h00000001;
        alu_exp[14] = 32'h12345000;
        alu_exp[15] = 32'h000000F2;
        alu_exp[16] = 32'h12345123;
        alu_exp[17] = 32'h00000001;
        alu_exp[18] = 32'h00000000;
        alu_exp[19] = 32'h00000001;
        alu_exp[20] = 32'h00000000;
        alu_exp[21] = 32'h00000002;
        alu_exp[22] = 32'h00000002;
        tick(100);
        for (int r = 7; r <= 22; r++) check($sformatf("alu_x%0d", r), xr(r), alu_exp[r]);

        // Mid-run reset aborts in-flight work and restarts from 0
        hold_reset();
        put(0, 32'h00500093);
        put(4, 32'h00108133);
        put(8, 32'h401101B3);
        release_reset();
        tick(3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_pc", dut.pc_if, 32'd0);
        for (int r = 0; r < 32; r++) check($sformatf("rst_x%0d", r), xr(r), 32'd0);
        tick(2);
        check("rst_hold_x1", xr(1), 32'd0);
        check("rst_hold_pc", dut.pc_if, 32'd0);
        release_reset();
        tick(4);
        check("rerun_x1_edge4", xr(1), 32'd0);
        tick(1);
        check("rerun_x1_edge5", xr(1), 32'd5);
        tick(12);
        check("rerun_x3", xr(3), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
